// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state type, 3 Mbps defaults, and a
// counter-width helper.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 120 MHz core clock / 3 Mbps line rate.
  localparam int CLKS_PER_BIT_3M = 40;
  localparam int UART_DATA_BITS  = 8;

  // Width of a counter that spans 0..n-1; at least one bit so that
  // degenerate sizes still give a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports: clk, rst_n (async active-low, clears both flops), d (async input),
//        q (synchronized output, 2 clk edges of latency).
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_tx_3m.sv
// UART transmitter (8N1 by default) gated by a synchronized PLL lock.
// Ports: clk, rst_n (async active-low), pll_locked (async), tx_data/tx_valid/
//        tx_ready (valid-ready handshake), txd (registered serial out, idle
//        high), busy (frame in progress).
module uart_tx_3m
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_3M,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  uart_state_t          state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 txd_nx;
  logic                 lock_s;
  logic                 bit_end;
  logic                 accept;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign bit_end = (cnt == CNT_LAST);

  // Ready in the final STOP cycle too, so the next start bit follows the
  // stop bit with no idle cycle in between.
  assign tx_ready = lock_s && ((state == IDLE) || ((state == STOP) && bit_end));
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      txd   <= txd_nx;
    end
  end

  // txd is computed one cycle ahead so the line changes exactly on the
  // edge that starts each bit.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    txd_nx   = txd;

    // Bit-cycle counter free-runs in every active state and wraps at each
    // bit boundary; it rests at zero in IDLE.
    if (state != IDLE) begin
      cnt_nx = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = START;
          shreg_nx = tx_data;
          txd_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          idx_nx   = '0;
          txd_nx   = shreg[0];
          shreg_nx = shreg >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            state_nx = STOP;
            idx_nx   = '0;
            txd_nx   = 1'b1;
          end else begin
            idx_nx   = idx + 1'b1;
            txd_nx   = shreg[0];
            shreg_nx = shreg >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (accept) begin
            state_nx = START;
            shreg_nx = tx_data;
            txd_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
            txd_nx   = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        txd_nx   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_3m.sv
// Self-checking bench for uart_tx_3m: a default 8N1/40-clock instance and a
// 7-bit/4-clock instance share clock, reset and lock. A line monitor decodes
// frames cycle-by-cycle against bytes queued when each acceptance happens.
module tb_uart_tx_3m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [6:0] tx_data_p;
  logic       tx_valid_p;
  logic       tx_ready_p;
  logic       txd_p;
  logic       busy_p;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];

  // Monitor selection: 0 = default instance, 1 = parameter instance.
  bit         sel = 1'b0;
  bit         mon_en = 1'b1;
  logic       mon_txd;
  int         mon_cpb;
  int         mon_bits;

  assign mon_txd  = sel ? txd_p : txd;
  assign mon_cpb  = sel ? 4 : 40;
  assign mon_bits = sel ? 7 : 8;

  uart_tx_3m u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy)
  );

  uart_tx_3m #(.CLKS_PER_BIT(4), .DATA_BITS(7)) u_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .tx_data    (tx_data_p),
    .tx_valid   (tx_valid_p),
    .tx_ready   (tx_ready_p),
    .txd        (txd_p),
    .busy       (busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) at negedges until the chosen instance shows tx_ready.
  task automatic wait_ready(input bit p, output bit ok);
    int n = 0;
    while (((p ? tx_ready_p : tx_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ((p ? tx_ready_p : tx_ready) === 1'b1);
  endtask

  // Count consecutive negedges with busy high, starting at the current one.
  task automatic count_busy(input bit p, output int n);
    n = 0;
    while (((p ? busy_p : busy) === 1'b1) && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Line monitor: on a start bit, pop the expected word and check that every
  // bit (start, data LSB first, stop) holds its value for all its cycles.
  always begin
    logic [7:0] expb;
    int         bits;
    int         cpb;
    logic       want;
    int         good;
    @(negedge clk);
    if (mon_en && mon_txd === 1'b0) begin
      bits = mon_bits;
      cpb  = mon_cpb;
      chk("frame_expected", exp_q.size() > 0, 1);
      expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      for (int b = 0; b < bits + 2; b++) begin
        want = (b == 0) ? 1'b0 : (b == bits + 1) ? 1'b1 : expb[b-1];
        good = 0;
        for (int c = 0; c < cpb; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (mon_txd === want) good++;
        end
        chk($sformatf("frame_%02h_bit%0d_cycles", expb, b), good, cpb);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, t1, t2, gap, rdy_seen, txd_bad, busy_seen;

    rst_n = 1'b1; pll_locked = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tx_valid_p = 1'b0; tx_data_p = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_txd_p", txd_p, 1);
    chk("rst_busy_p", busy_p, 0);

    // Lock already up during reset must not leak through.
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready_locked", tx_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rel_ready_c1", tx_ready, 0);
    @(negedge clk); chk("rel_ready_c2", tx_ready, 0);
    @(negedge clk); chk("rel_ready_c3", tx_ready, 1);

    // Single frame 0xA5.
    tx_data = 8'hA5; tx_valid = 1'b1;
    chk("a5_pre_txd", txd, 1);
    chk("a5_pre_busy", busy, 0);
    exp_q.push_back(8'hA5);
    @(negedge clk); tx_valid = 1'b0;
    chk("a5_lat_txd", txd, 0);
    chk("a5_busy_rise", busy, 1);
    count_busy(0, n);
    chk("a5_busy_len", n, 400);
    @(negedge clk);

    // Back-to-back 0x55 then 0x0F with tx_valid held.
    tx_data = 8'h55; tx_valid = 1'b1;
    wait_ready(0, ok);
    chk("b2b_ready1", ok, 1);
    exp_q.push_back(8'h55); t1 = cyc;
    @(negedge clk); tx_data = 8'h0F;
    n = 0; gap = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      if (busy !== 1'b1) gap++;
      @(negedge clk); n++;
    end
    chk("b2b_ready2", tx_ready, 1);
    t2 = cyc;
    exp_q.push_back(8'h0F);
    chk("b2b_period", t2 - t1, 400);
    chk("b2b_busy_gap", gap, 0);
    @(negedge clk); tx_valid = 1'b0;
    chk("b2b_start2_txd", txd, 0);
    chk("b2b_start2_busy", busy, 1);
    count_busy(0, n);
    chk("b2b_busy_len2", n, 400);
    @(negedge clk);

    // Lock gating: no lock, valid held for 1000 cycles.
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    tx_data = 8'h99; tx_valid = 1'b1;
    rdy_seen = 0; txd_bad = 0; busy_seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) rdy_seen++;
      if (txd !== 1'b1) txd_bad++;
      if (busy !== 1'b0) busy_seen++;
    end
    chk("nolock_ready_cycles", rdy_seen, 0);
    chk("nolock_txd_low_cycles", txd_bad, 0);
    chk("nolock_busy_cycles", busy_seen, 0);
    tx_valid = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    chk("lock_ready_edge_2or3", (n >= 2 && n <= 3), 1);

    // Lock lost at cycle 150 of a 0xFF frame; tx_data churns meanwhile.
    tx_data = 8'hFF; tx_valid = 1'b1;
    wait_ready(0, ok);
    chk("ff_ready", ok, 1);
    exp_q.push_back(8'hFF);
    @(negedge clk); tx_valid = 1'b0;
    repeat (149) begin
      tx_data = 8'($urandom);
      @(negedge clk);
    end
    pll_locked = 1'b0;
    rdy_seen = 0; n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (tx_ready !== 1'b0) rdy_seen++;
      tx_data = 8'($urandom);
      @(negedge clk); n++;
    end
    chk("ff_busy_tail", n, 251);
    chk("ff_ready_during_loss", rdy_seen, 0);
    tx_valid = 1'b1; rdy_seen = 0; txd_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) rdy_seen++;
      if (txd !== 1'b1) txd_bad++;
    end
    chk("ff_ready_after_loss", rdy_seen, 0);
    chk("ff_txd_after_loss", txd_bad, 0);
    tx_valid = 1'b0;
    pll_locked = 1'b1;
    wait_ready(0, ok);
    chk("relock_ready", ok, 1);
    @(negedge clk);

    // Reset at cycle 200 of a 0x3C frame aborts it.
    mon_en = 1'b0;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready(0, ok);
    chk("abort_relock_ready", ok, 1);
    chk("abort_no_resume_txd", txd, 1);
    chk("abort_no_resume_busy", busy, 0);
    mon_en = 1'b1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk); tx_valid = 1'b0;
    chk("3c_lat_txd", txd, 0);
    count_busy(0, n);
    chk("3c_busy_len", n, 400);
    @(negedge clk);

    // Parameter instance: 4 clocks/bit, 7 data bits.
    sel = 1'b1;
    @(negedge clk);
    tx_data_p = 7'h4B; tx_valid_p = 1'b1;
    wait_ready(1, ok);
    chk("p_ready", ok, 1);
    exp_q.push_back({1'b0, 7'h4B});
    @(negedge clk); tx_valid_p = 1'b0;
    chk("p_lat_txd", txd_p, 0);
    count_busy(1, n);
    chk("p_busy_len", n, 36);
    @(negedge clk);
    tx_data_p = 7'h35; tx_valid_p = 1'b1;
    wait_ready(1, ok);
    chk("p_ready2", ok, 1);
    exp_q.push_back({1'b0, 7'h35});
    @(negedge clk); tx_valid_p = 1'b0;
    count_busy(1, n);
    chk("p_busy_len2", n, 36);
    repeat (2) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_3m.md
UART_TX_3M -- requirements
Module: uart_tx_3m

Interface
REQ-001 Parameter CLKS_PER_BIT, default 40, is the number of clk cycles per serial bit (120 MHz / 3 Mbps).
REQ-002 Parameter DATA_BITS, default 8, is the number of payload bits per frame.
REQ-003 clk  input  1  single clock, the 120 MHz PLL output; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pll_locked  input  1  PLL lock indication; asynchronous to clk.
REQ-006 tx_data  input  DATA_BITS  byte to transmit; sampled on acceptance.
REQ-007 tx_valid  input  1  upstream offers tx_data.
REQ-008 tx_ready  output  1  block accepts tx_data this cycle.
REQ-009 txd  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  a frame is in progress (any state other than IDLE).

Function
REQ-011 pll_locked shall pass through a 2-flop synchronizer; the result is lock_s.
REQ-012 Acceptance shall occur on a cycle where tx_valid and tx_ready are both 1; tx_data is captured into a shift register on that edge.
REQ-013 tx_ready shall be 1 only when lock_s=1 and the FSM is in IDLE, or in the last cycle of STOP.
REQ-014 The FSM states shall be IDLE, START, DATA and STOP.
REQ-015 IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after DATA_BITS bits; STOP->IDLE after CLKS_PER_BIT cycles, or STOP->START when an acceptance occurs in the last STOP cycle.
REQ-016 txd shall go low on the first edge after acceptance (latency 1 cycle).
REQ-017 The frame shall be txd=0 for the start bit, then the data bits LSB first, then txd=1 for the stop bit; each bit is held exactly CLKS_PER_BIT cycles.
REQ-018 Back-to-back frames shall have a period of exactly (DATA_BITS+2)*CLKS_PER_BIT cycles, i.e. 400 at the default parameter values, with no extra idle cycle.
REQ-019 The bit-cycle counter shall be ceil(log2(CLKS_PER_BIT)) bits wide and shall count 0..CLKS_PER_BIT-1, then wrap to 0 at each bit boundary.
REQ-020 The bit index counter shall count 0..DATA_BITS-1.
REQ-021 tx_data changes while not accepted shall have no effect on txd.
REQ-022 If lock_s falls mid-frame, the current frame shall complete unaltered; tx_ready shall stay 0 until lock_s returns.
REQ-023 While lock_s=0 in IDLE, txd shall be 1, busy 0 and tx_ready 0, and tx_valid shall be ignored.
REQ-024 busy shall be 1 from the cycle after acceptance until STOP->IDLE.
REQ-025 busy shall stay 1 continuously across back-to-back frames.

Reset
REQ-026 rst_n=0 shall immediately force: FSM=IDLE, txd=1, tx_ready=0, busy=0, counters=0, shift register=0, synchronizer flops=0.
REQ-027 Reset asserted mid-frame shall abort the frame; no partial bits resume after release.
REQ-028 After rst_n rises, tx_ready shall stay 0 for at least 2 cycles (synchronizer fill), even if pll_locked is already 1.

Structure
REQ-029 Shared package uart_pkg shall hold the state enum typedef, CLKS_PER_BIT_3M=40 and UART_DATA_BITS=8.
REQ-030 The lock synchronizer shall be a separate sub-module, sync2 (2-flop, async active-low reset, reset value 0).
REQ-031 The rest shall be one FSM plus datapath in uart_tx_3m.

Verification
REQ-032 Single frame: lock=1, accept 0xA5 -> txd low 1 cycle later, then data bits 1,0,1,0,0,1,0,1 at 40 cycles each, then stop high; busy=1 for exactly 400 cycles.
REQ-033 Back-to-back: tx_valid held 1 with 0x55 then 0x0F -> second start bit begins exactly 400 cycles after the first; txd never high between the frames.
REQ-034 Lock gating: pll_locked=0, tx_valid=1 for 1000 cycles -> txd stays 1 and tx_ready stays 0; raise lock -> tx_ready=1 on the 2nd or 3rd edge after.
REQ-035 Lock loss mid-frame: drop pll_locked at cycle 150 of a 0xFF frame -> frame completes correctly; tx_ready stays 0 afterwards.
REQ-036 Reset mid-frame: assert rst_n=0 at cycle 200 -> txd=1 and busy=0 immediately (asynchronously); after release with lock=1, a new 0x3C frame transmits correctly.
REQ-037 Parameter: CLKS_PER_BIT=4, DATA_BITS=7 -> 36-cycle frame, LSB first.
